// File: rtl/lc3b_pipe_pkg.sv
// Shared LC-3b pipeline definitions.
//   PCMUX_*       redirect selector encodings driven by the MEM stage
//   XLEN_DEFAULT  native datapath width
//   fetch_entry_t one fetch-queue entry at native width: {npc, ir}
package lc3b_pipe_pkg;

  localparam logic [1:0] PCMUX_SEQ  = 2'd0;
  localparam logic [1:0] PCMUX_BR   = 2'd1;
  localparam logic [1:0] PCMUX_TRAP = 2'd2;
  localparam logic [1:0] PCMUX_RST  = 2'd3;

  localparam int XLEN_DEFAULT = 16;

  // npc sits in the upper half; the fetch queue packs its word the same way
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] npc;
    logic [XLEN_DEFAULT-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for the fetch queue.
//   clk, rst_n   clock / async active-low reset
//   push_i       write wdata_i at the tail (ignored when full without a pop)
//   pop_i        advance the head (ignored when empty)
//   flush_i      drop all entries; wins over push/pop
//   wdata_i      write word
//   rdata_o      head word (undefined when empty)
//   full_o       count == DEPTH
//   empty_o      count == 0
//   count_o      occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_push = push_i & ~flush_i & (~full_o | pop_i);
  assign do_pop  = pop_i  & ~flush_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry {npc, ir} queue between I-mem and the DE latch.
//   clk, rst_n       clock / async active-low reset
//   imem_req/addr    one read per cycle at the current PC
//   imem_r, instr    I-mem ready and returned word for imem_addr
//   dep_stall        DE dependency stall
//   mem_stall        D-mem stall
//   br_stall         a valid branch is in flight downstream; hold the head
//   mem_pcmux        redirect select (SEQ/BR/TRAP/RST)
//   target_pc        taken-branch target
//   trap_pc          trap vector target
//   ld_de            DE latch load enable
//   de_v/npc/ir      queue head presented to DE, zeroed when not valid
module fetch_queue_stage
  import lc3b_pipe_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_r,
  input  logic [XLEN-1:0] instr,
  input  logic            dep_stall,
  input  logic            mem_stall,
  input  logic            br_stall,
  input  logic [1:0]      mem_pcmux,
  input  logic [XLEN-1:0] target_pc,
  input  logic [XLEN-1:0] trap_pc,
  output logic            ld_de,
  output logic            de_v,
  output logic [XLEN-1:0] de_npc,
  output logic [XLEN-1:0] de_ir
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_plus2;
  logic              redirect, push, pop;
  logic [2*XLEN-1:0] q_wdata, q_rdata;
  logic              q_empty;
  logic              unused_full;
  logic [CW-1:0]     q_count;

  assign pc_plus2 = pc_q + XLEN'(2);   // wraps modulo 2^XLEN
  assign redirect = (mem_pcmux != PCMUX_SEQ);

  assign ld_de = ~(dep_stall | mem_stall);
  assign pop   = ld_de & ~q_empty & ~br_stall & ~redirect;

  // rst_n gates the request so nothing is issued while reset is held,
  // even though the queue already reads empty.
  assign imem_req = rst_n & ~br_stall & ~redirect & ((q_count < CW'(DEPTH)) | pop);
  assign push     = imem_req & imem_r;
  assign imem_addr = pc_q;

  // Redirect outranks the sequential advance; a dropped response leaves pc alone.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      unique case (mem_pcmux)
        PCMUX_BR:   pc_d = target_pc;
        PCMUX_TRAP: pc_d = trap_pc;
        default:    pc_d = RESET_PC;
      endcase
    end else if (push) begin
      pc_d = pc_plus2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign q_wdata = {pc_plus2, instr};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (q_wdata),
    .rdata_o (q_rdata),
    .full_o  (unused_full),   // the request uses count so the pop bypass stays explicit
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // No bypass: a word pushed this cycle is only visible from the next cycle.
  assign de_v   = ~q_empty & ~br_stall;
  assign de_npc = de_v ? q_rdata[2*XLEN-1:XLEN] : '0;
  assign de_ir  = de_v ? q_rdata[XLEN-1:0]      : '0;

endmodule

// File: tb/tb_fetch_queue_stage.sv
module tb_fetch_queue_stage;
  import lc3b_pipe_pkg::*;

  localparam int N = 3;
  localparam int DEP [N] = '{4, 2, 8};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_r, dep_stall, mem_stall, br_stall;
  logic [1:0]  mem_pcmux;
  logic [15:0] instr, target_pc, trap_pc;

  logic        req_w  [N];
  logic [15:0] addr_w [N];
  logic        ld_w   [N];
  logic        dev_w  [N];
  logic [15:0] npc_w  [N];
  logic [15:0] ir_w   [N];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : gi
      fetch_queue_stage #(.XLEN(16), .DEPTH(DEP[g]), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_w[g]), .imem_addr(addr_w[g]),
        .imem_r(imem_r), .instr(instr),
        .dep_stall(dep_stall), .mem_stall(mem_stall), .br_stall(br_stall),
        .mem_pcmux(mem_pcmux), .target_pc(target_pc), .trap_pc(trap_pc),
        .ld_de(ld_w[g]), .de_v(dev_w[g]), .de_npc(npc_w[g]), .de_ir(ir_w[g])
      );
    end
  endgenerate

  // hand-computed pins on the DEPTH=4 instance
  logic        pin_en = 1'b0;
  string       pin_nm;
  logic        pin_req, pin_dev;
  logic [15:0] pin_npc, pin_addr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s D=%0d t=%0t got %h want %h", nm, DEP[k], $time, act, exp);
    end
  endtask

  // Model: a plain queue of {npc, ir} and a pc per depth, stepped once per cycle.
  // Inputs only change just after the rising edge (reset may fall a little later),
  // so the falling edge sees exactly what the next rising edge will act on.
  fetch_entry_t mq [N][$];
  logic [15:0]  mpc [N];

  initial begin : cmp
    fetch_entry_t e;
    int  sz;
    bit  redir, pop, e_req, e_dev, e_ld;
    logic [15:0] e_npc, e_ir;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!rst_n) begin
          mq[k].delete();
          mpc[k] = 16'h0000;
        end
        sz    = mq[k].size();
        redir = (mem_pcmux != 2'd0);
        e_ld  = !(dep_stall || mem_stall);
        e_dev = (sz > 0) && !br_stall;
        pop   = e_ld && (sz > 0) && !br_stall && !redir;
        e_req = rst_n && !br_stall && !redir && ((sz < DEP[k]) || pop);
        e_npc = e_dev ? mq[k][0].npc : 16'h0;
        e_ir  = e_dev ? mq[k][0].ir  : 16'h0;

        chk("imem_req",  k, 32'(req_w[k]),  32'(e_req));
        chk("imem_addr", k, 32'(addr_w[k]), 32'(mpc[k]));
        chk("ld_de",     k, 32'(ld_w[k]),   32'(e_ld));
        chk("de_v",      k, 32'(dev_w[k]),  32'(e_dev));
        chk("de_npc",    k, 32'(npc_w[k]),  32'(e_npc));
        chk("de_ir",     k, 32'(ir_w[k]),   32'(e_ir));

        if (pin_en && k == 0) begin
          chk({pin_nm, ".req"},  k, 32'(req_w[k]),  32'(pin_req));
          chk({pin_nm, ".dev"},  k, 32'(dev_w[k]),  32'(pin_dev));
          chk({pin_nm, ".npc"},  k, 32'(npc_w[k]),  32'(pin_npc));
          chk({pin_nm, ".addr"}, k, 32'(addr_w[k]), 32'(pin_addr));
          chk({pin_nm, ".model_req"},  k, 32'(e_req),  32'(pin_req));
          chk({pin_nm, ".model_npc"},  k, 32'(e_npc),  32'(pin_npc));
          chk({pin_nm, ".model_addr"}, k, 32'(mpc[k]), 32'(pin_addr));
        end

        if (rst_n) begin
          if (redir) begin
            mq[k].delete();
            case (mem_pcmux)
              2'd1:    mpc[k] = target_pc;
              2'd2:    mpc[k] = trap_pc;
              default: mpc[k] = 16'h0000;
            endcase
          end else begin
            if (pop) void'(mq[k].pop_front());
            if (e_req && imem_r) begin
              e.npc = mpc[k] + 16'd2;
              e.ir  = instr;
              mq[k].push_back(e);
              mpc[k] = mpc[k] + 16'd2;
            end
          end
        end
      end
    end
  end

  int cyc = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      instr = 16'hA000 ^ 16'(cyc * 37);
    end
  endtask

  task automatic pin(input string nm, input logic req, input logic dev,
                     input logic [15:0] npc, input logic [15:0] addr);
    pin_nm = nm; pin_req = req; pin_dev = dev; pin_npc = npc; pin_addr = addr;
    pin_en = 1'b1;
    @(negedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  logic [47:0] pr, pd, pb, pm;

  initial begin
    rst_n = 1'b0; imem_r = 1'b1; dep_stall = 1'b0; mem_stall = 1'b0; br_stall = 1'b0;
    mem_pcmux = 2'd0; target_pc = 16'h0; trap_pc = 16'h0; instr = 16'hA000;

    // 1: reset, then stream
    step(2);
    pin("reset", 1'b0, 1'b0, 16'h0, 16'h0);
    step(1); rst_n = 1'b1;
    pin("release", 1'b1, 1'b0, 16'h0, 16'h0);
    step(1);
    pin("first", 1'b1, 1'b1, 16'h0002, 16'h0002);

    // 2: fill under dep_stall, then drain with concurrent refill
    step(1); rst_pulse(); dep_stall = 1'b1;
    step(5);
    pin("full", 1'b0, 1'b1, 16'h0002, 16'h0008);
    step(1); dep_stall = 1'b0;
    pin("drain0", 1'b1, 1'b1, 16'h0002, 16'h0008);
    step(1);
    pin("drain1", 1'b1, 1'b1, 16'h0004, 16'h000A);

    // 3: branch stall then BR redirect
    step(1); br_stall = 1'b1;
    pin("brstall", 1'b0, 1'b0, 16'h0, 16'h000C);
    step(2);
    step(1); br_stall = 1'b0; mem_pcmux = 2'd1; target_pc = 16'h3000;
    pin("br", 1'b0, 1'b1, 16'h0006, 16'h000C);
    step(1); mem_pcmux = 2'd0;
    pin("br_next", 1'b1, 1'b0, 16'h0, 16'h3000);
    step(1);
    pin("br_first", 1'b1, 1'b1, 16'h3002, 16'h3002);

    // 4: trap drops the response; reset vector
    step(1); mem_pcmux = 2'd2; trap_pc = 16'h0200;
    pin("trap", 1'b0, 1'b1, 16'h3004, 16'h3004);
    step(1); mem_pcmux = 2'd0;
    pin("trap_next", 1'b1, 1'b0, 16'h0, 16'h0200);
    step(1); mem_pcmux = 2'd3;
    pin("rstvec", 1'b0, 1'b1, 16'h0202, 16'h0202);
    step(1); mem_pcmux = 2'd0;
    pin("rstvec_next", 1'b1, 1'b0, 16'h0, 16'h0000);

    // 5: pc wrap, then a mixed soak that wraps the queue pointers
    step(1); mem_pcmux = 2'd1; target_pc = 16'hFFFE;
    step(1); mem_pcmux = 2'd0;
    pin("wrap0", 1'b1, 1'b0, 16'h0, 16'hFFFE);
    step(1);
    pin("wrap1", 1'b1, 1'b1, 16'h0000, 16'h0000);
    pr = 48'hF7BD_EF6B_5AFF; pd = 48'h0F0C_3300_F0CC; pb = 48'h0010_0200_4008; pm = 48'h0000_8100_0C00;
    for (int i = 0; i < 48; i++) begin
      step(1);
      imem_r = pr[i]; dep_stall = pd[i]; br_stall = pb[i]; mem_stall = pm[i];
      mem_pcmux = (i == 20) ? 2'd1 : 2'd0;
      target_pc = 16'h1234;
    end
    step(1); imem_r = 1'b1; dep_stall = 1'b0; br_stall = 1'b0; mem_stall = 1'b0; mem_pcmux = 2'd0;

    // 6: async reset with three entries queued
    step(1); rst_pulse(); dep_stall = 1'b1;
    step(3);
    #1 rst_n = 1'b0;
    pin("async_rst", 1'b0, 1'b0, 16'h0, 16'h0000);
    step(1); rst_n = 1'b1; dep_stall = 1'b0;
    pin("after_rst", 1'b1, 1'b0, 16'h0, 16'h0000);
    step(4);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
